dmem_seq: RTL and testbench

DMEM_SEQ -- requirements
Module: dmem_seq

---
 rtl/y86_pkg.sv | 37 +++
 rtl/dmem_seq_if.sv | 26 ++
 rtl/dmem_seq.sv | 188 ++++++++++++++++++
 tb/tb_dmem_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage.
//   - icode constants for the instructions that touch data memory (plus HALT)
//   - status codes reported with each completed access
//   - sequencer state encoding
//   - addr_err(): true when an 8-byte access at 'addr' would leave the
//     16-bit data address space
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'd0;
    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Highest legal base is 0xFFF8 so that base + 7 still fits in 16 bits.
    function automatic logic addr_err(input logic [63:0] addr);
        return (addr[63:16] != 48'd0) || (addr[15:0] > 16'hFFF8);
    endfunction

endpackage

// File: rtl/dmem_seq_if.sv
// Byte-wide data RAM bus between dmem_seq and the external RAM.
//   mem_addr  : byte address
//   mem_wdata : write byte
//   mem_we    : byte write enable
//   mem_re    : byte read enable
//   mem_rdata : read byte, valid one cycle after mem_re
// master = sequencer side, slave = RAM side.
interface dmem_seq_if;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_seq.sv
// Y86-64 memory-stage sequencer: turns one 64-bit load/store into eight
// little-endian byte beats on an external byte-wide RAM.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : request an access (sampled only while idle)
//   icode             : instruction code, selects write/read/no-access
//   valE, valA, valP  : address and write-data sources
//   instr_valid       : decode-valid flag (feeds status)
//   imem_error        : fetch address error (feeds status)
//   mem               : byte RAM bus (master side)
//   valM              : assembled read word, held until the next read
//   busy              : high whenever not idle
//   done              : one-cycle completion pulse
//   dmem_err, stat    : data address error and status, valid with done,
//                       held until the next done
module dmem_seq
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [63:0]       valE,
    input  logic [63:0]       valA,
    input  logic [63:0]       valP,
    input  logic              instr_valid,
    input  logic              imem_error,
    dmem_seq_if.master        mem,
    output logic [63:0]       valM,
    output logic              busy,
    output logic              done,
    output logic              dmem_err,
    output logic [1:0]        stat
);

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] base_q, base_d;
    logic [63:0] wdata_q, wdata_d;
    stat_e       pend_stat_q, pend_stat_d;
    logic        pend_err_q, pend_err_d;
    logic [63:0] valm_q, valm_d;
    stat_e       stat_q, stat_d;
    logic        dmem_err_q, dmem_err_d;

    // Request decode, only meaningful in the cycle start is accepted.
    logic        is_wr, is_rd;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_err;
    stat_e       req_stat;
    logic [2:0]  rd_idx;

    always_comb begin
        is_wr     = (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
        is_rd     = (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ)  || (icode == ICODE_RET);
        req_addr  = ((icode == ICODE_POPQ) || (icode == ICODE_RET)) ? valA : valE;
        req_wdata = (icode == ICODE_CALL) ? valP : valA;
        req_err   = (is_wr || is_rd) && addr_err(req_addr);

        if (icode == ICODE_HALT) begin
            req_stat = STAT_HLT;
        end else if (req_err || imem_error) begin
            req_stat = STAT_ADR;
        end else if (!instr_valid) begin
            req_stat = STAT_INS;
        end else begin
            req_stat = STAT_AOK;
        end
    end

    // Read data lags mem_re by one cycle, so the byte arriving now belongs to
    // beat k_q-1. k_q wraps 7 -> 0 on entry to DRAIN, which makes the same
    // subtraction yield 7 for the final byte.
    assign rd_idx = k_q - 3'd1;

    // NOTE: every combinationally assigned signal gets a default at the top of
    // the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        pend_stat_d = pend_stat_q;
        pend_err_d  = pend_err_q;
        valm_d      = valm_q;
        stat_d      = stat_q;
        dmem_err_d  = dmem_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = req_addr[15:0];
                    wdata_d     = req_wdata;
                    pend_stat_d = req_stat;
                    pend_err_d  = req_err;
                    k_d         = 3'd0;
                    if ((is_wr || is_rd) && !req_err) begin
                        state_d = is_wr ? S_WRITE : S_READ;
                    end else begin
                        state_d    = S_DONE;
                        stat_d     = req_stat;
                        dmem_err_d = req_err;
                    end
                end
            end
            S_WRITE: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d    = S_DONE;
                    stat_d     = pend_stat_q;
                    dmem_err_d = pend_err_q;
                end
            end
            S_READ: begin
                k_d = k_q + 3'd1;
                if (k_q != 3'd0) begin
                    valm_d[{rd_idx, 3'b000} +: 8] = mem.mem_rdata;
                end
                if (k_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                valm_d[{rd_idx, 3'b000} +: 8] = mem.mem_rdata;
                state_d    = S_DONE;
                stat_d     = pend_stat_q;
                dmem_err_d = pend_err_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= 3'd0;
            base_q      <= 16'd0;
            wdata_q     <= 64'd0;
            pend_stat_q <= STAT_AOK;
            pend_err_q  <= 1'b0;
            valm_q      <= 64'd0;
            stat_q      <= STAT_AOK;
            dmem_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            pend_stat_q <= pend_stat_d;
            pend_err_q  <= pend_err_d;
            valm_q      <= valm_d;
            stat_q      <= stat_d;
            dmem_err_q  <= dmem_err_d;
        end
    end

    // Bus outputs decode straight from state so a reset drops them at once
    // and nothing is driven outside the byte beats.
    always_comb begin
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;
        mem.mem_addr  = 16'd0;
        mem.mem_wdata = 8'd0;
        if (state_q == S_WRITE) begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = base_q + 16'(k_q);
            mem.mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
        end else if (state_q == S_READ) begin
            mem.mem_re    = 1'b1;
            mem.mem_addr  = base_q + 16'(k_q);
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign valM     = valm_q;
    assign stat     = stat_q;
    assign dmem_err = dmem_err_q;

endmodule

// File: tb/tb_dmem_seq.sv
// Self-checking bench for dmem_seq: directed cases followed by randomized
// transactions, each predicted by a byte-array memory model and a per-opcode
// classification.
module tb_dmem_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        instr_valid, imem_error;
    logic [63:0] valM;
    logic        busy, done, dmem_err;
    logic [1:0]  stat;

    dmem_seq_if mem_if ();

    dmem_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .icode       (icode),
        .valE        (valE),
        .valA        (valA),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .mem         (mem_if),
        .valM        (valM),
        .busy        (busy),
        .done        (done),
        .dmem_err    (dmem_err),
        .stat        (stat)
    );

    always #5 clk = ~clk;

    // External byte RAM.
    logic [7:0] ram [0:65535] = '{default: 8'h00};

    always @(posedge clk) begin
        if (mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
        if (mem_if.mem_re) mem_if.mem_rdata <= ram[mem_if.mem_addr];
    end

    // Reference model state.
    logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
    logic [63:0] model_valm = 64'd0;
    int          exp_dones  = 0;

    int n_checks = 0;
    int n_fail   = 0;

    int overlap_cnt = 0;
    int done_total  = 0;

    always @(negedge clk) begin
        if (mem_if.mem_we && mem_if.mem_re) overlap_cnt++;
        if (done) done_total++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(16'h0400, 16'h04FF));
            1:       return 64'($urandom_range(16'hFFF0, 16'hFFFF));
            2:       return rand64();
            default: return 64'($urandom_range(16'h0500, 16'h05F8));
        endcase
    endfunction

    // One transaction: predict from the opcode rules, drive start for one
    // edge, then watch up to 20 cycles for done. poke re-asserts start while
    // the access is in flight.
    task automatic run_txn(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                           input logic [63:0] vp, input logic iv, input logic ie,
                           input bit poke, input string tag);
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
        bit          err;
        int          es;
        int          exp_lat;
        int          lat;
        int          we_n;
        int          re_n;
        logic [63:0] exp_word;

        kind = (ic == 4 || ic == 10 || ic == 8) ? 1 : (ic == 5 || ic == 11 || ic == 9) ? 2 : 0;
        addr = (ic == 11 || ic == 9) ? va : ve;
        data = (ic == 8) ? vp : va;
        err  = (kind != 0) && (({1'b0, addr} + 65'd7) > 65'd65535);
        if (ic == 0)           es = 1;
        else if (err || ie)    es = 2;
        else if (!iv)          es = 3;
        else                   es = 0;
        exp_lat = (kind == 0 || err) ? 1 : (kind == 1) ? 9 : 10;

        @(negedge clk);
        icode = ic; valE = ve; valA = va; valP = vp;
        instr_valid = iv; imem_error = ie; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        icode = 4'($urandom); valE = rand64(); valA = rand64(); valP = rand64();
        instr_valid = 1'($urandom); imem_error = 1'($urandom);

        lat = 0; we_n = 0; re_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (mem_if.mem_we) we_n++;
            if (mem_if.mem_re) re_n++;
            if (done) begin
                lat = n;
                break;
            end
            if (poke && n == 4) begin
                icode = 4'd4; valE = 64'h0000_0000_0000_0600; start = 1'b1;
            end
            if (poke && n == 5) start = 1'b0;
        end
        exp_dones++;

        if (kind == 2 && !err) begin
            for (int i = 7; i >= 0; i--) exp_word = {exp_word[55:0], ref_mem[addr[15:0] + 16'(i)]};
            model_valm = exp_word;
        end
        if (kind == 1 && !err) begin
            for (int i = 0; i < 8; i++) ref_mem[addr[15:0] + 16'(i)] = data[8*i +: 8];
        end

        check({tag, " done latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " mem_we cycles"}, 64'(we_n), 64'((kind == 1 && !err) ? 8 : 0));
        check({tag, " mem_re cycles"}, 64'(re_n), 64'((kind == 2 && !err) ? 8 : 0));
        check({tag, " stat"}, 64'(stat), 64'(es));
        check({tag, " dmem_err"}, 64'(dmem_err), 64'(err));
        check({tag, " valM"}, valM, model_valm);

        @(negedge clk);
        check({tag, " idle after done"}, {62'd0, busy, done}, 64'd0);
        check({tag, " stat held"}, {61'd0, dmem_err, stat}, {61'd0, 1'(err), 2'(es)});
    endtask

    logic [63:0] word;
    int          dones_before;
    int          ram_diff;

    initial begin
        rst = 1'b0; start = 1'b0; icode = 4'd0;
        valE = 64'd0; valA = 64'd0; valP = 64'd0;
        instr_valid = 1'b1; imem_error = 1'b0;

        // Reset state.
        #12;
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset we/re", {62'd0, mem_if.mem_we, mem_if.mem_re}, 64'd0);
        check("reset addr/wdata", {40'd0, mem_if.mem_addr, mem_if.mem_wdata}, 64'd0);
        check("reset valM", valM, 64'd0);
        check("reset stat/err", {61'd0, dmem_err, stat}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic write then read-back.
        run_txn(4'd4, 64'h100, 64'h1122334455667788, 64'h0, 1'b1, 1'b0, 1'b0, "rmmovq");
        for (int i = 7; i >= 0; i--) word = {word[55:0], ram[16'h0100 + 16'(i)]};
        check("rmmovq ram bytes", word, 64'h1122334455667788);
        run_txn(4'd5, 64'h100, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, "mrmovq");

        // Top-of-memory boundary: 0xFFF8 legal, 0xFFF9 faults.
        run_txn(4'd10, 64'hFFF8, 64'hCAFEF00D_DEADBEEF, 64'h0, 1'b1, 1'b0, 1'b0, "pushq top");
        run_txn(4'd11, 64'h0, 64'hFFF8, 64'h0, 1'b1, 1'b0, 1'b0, "popq top");
        run_txn(4'd8, 64'hFFF9, 64'h0, 64'h55AA, 1'b1, 1'b0, 1'b0, "call 0xFFF9");

        // Status priority.
        run_txn(4'd0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, "halt+imem_err");
        run_txn(4'd1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, "nop invalid");

        // Busy guard: second start during a read is ignored.
        run_txn(4'd9, 64'h0, 64'h100, 64'h0, 1'b1, 1'b0, 1'b1, "ret busy guard");

        // Reset abort at beat 3 of a write.
        @(negedge clk);
        icode = 4'd4; valE = 64'h200; valA = 64'hA1B2C3D4E5F60718; instr_valid = 1'b1;
        imem_error = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort beat3 addr", {47'd0, mem_if.mem_we, mem_if.mem_addr}, {47'd0, 1'b1, 16'h0203});
        dones_before = done_total;
        rst = 1'b0;
        #1;
        check("abort we dropped", {61'd0, mem_if.mem_we, busy, done}, 64'd0);
        check("abort addr cleared", 64'(mem_if.mem_addr), 64'd0);
        for (int i = 0; i < 3; i++) ref_mem[16'h0200 + 16'(i)] = valA[8*i +: 8];
        model_valm = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("abort no done", 64'(done_total), 64'(dones_before));
        for (int i = 7; i >= 0; i--) word = {word[55:0], ram[16'h0200 + 16'(i)]};
        check("abort ram bytes", word, 64'h0000_0000_00F6_0718);
        check("abort valM cleared", valM, 64'd0);
        run_txn(4'd5, 64'h200, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, "read after abort");

        // Randomized transactions.
        for (int t = 0; t < 24; t++) begin
            run_txn(4'($urandom_range(0, 15)), rand_addr(), rand_addr(), rand64(),
                    1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
                    1'b0, $sformatf("rand%0d", t));
        end

        // Global properties.
        repeat (2) @(negedge clk);
        check("we/re overlap", 64'(overlap_cnt), 64'd0);
        check("done pulse count", 64'(done_total), 64'(exp_dones));
        ram_diff = 0;
        for (int a = 0; a < 65536; a++) if (ram[a] !== ref_mem[a]) ram_diff++;
        check("ram vs model", 64'(ram_diff), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
